// File: rtl/btr_arbiter_pkg.sv
// Shared definitions for the bit-reverse arbiter: the fixed datapath width,
// the requester identifiers, and the result-slot state encoding.
package btr_arbiter_pkg;

    // The bit-reverse unit is hard-wired to this width.
    localparam int BTR_WIDTH = 16;

    // Requester identifiers. They are also used for the owner and priority registers.
    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    // Result slot state. HELD means the one-entry result register is occupied.
    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } slot_state_t;

    // Returns the requester that is not the given one.
    // Used to rotate priority after a grant.
    function automatic req_id_t other_req(input req_id_t id);
        return (id == REQ0) ? REQ1 : REQ0;
    endfunction

endpackage

// File: rtl/btr_calc.sv
// Combinational 16-bit bit-reverse unit: bit i of dout is bit 15-i of din.
module btr_calc
    import btr_arbiter_pkg::*;
(
    input  logic [BTR_WIDTH-1:0] din,
    output logic [BTR_WIDTH-1:0] dout
);

    // Pure wiring: each output bit is taken from the mirrored input bit.
    generate
        for (genvar gi = 0; gi < BTR_WIDTH; gi++) begin : g_rev
            assign dout[gi] = din[BTR_WIDTH-1-gi];
        end
    endgenerate

endmodule

// File: rtl/btr_arbiter.sv
// Two-requester round-robin arbiter in front of one shared bit-reverse unit.
// The winning operand is reversed into a one-entry result register that is
// tagged with its owner. The result is returned on the owner's response channel.
// A drain and a new acceptance can happen in the same cycle, which allows
// one operation per cycle.
module btr_arbiter
    import btr_arbiter_pkg::*;
#(
    // Only 16 is legal: the bit-reverse unit has a fixed width.
    parameter int WIDTH = BTR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             resp0_valid,
    output logic [WIDTH-1:0] resp0_data,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    output logic [WIDTH-1:0] resp1_data,
    input  logic             resp1_ready,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1
);

    slot_state_t      state_reg;
    req_id_t          owner_reg;
    req_id_t          prio_reg;
    logic [WIDTH-1:0] result_reg;
    logic [15:0]      grant_cnt0_reg;
    logic [15:0]      grant_cnt1_reg;

    logic             full;
    logic             owner_ready;
    logic             drain;
    logic             slot_ok;
    logic             grant_valid;
    req_id_t          grant_id;
    logic             accept;
    logic [WIDTH-1:0] granted_data;
    logic [WIDTH-1:0] rev_data;

    // Slot status. The slot is free when it is empty.
    // It is also free when the owner takes the held result this cycle.
    assign full        = (state_reg == HELD);
    assign owner_ready = (owner_reg == REQ1) ? resp1_ready : resp0_ready;
    assign drain       = full & owner_ready;
    assign slot_ok     = ~full | drain;

    // Round-robin grant.
    // If both requesters are valid, the grant goes to prio_reg.
    // Otherwise the only valid requester wins.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = prio_reg;
        end else if (req1_valid) begin
            grant_id = REQ1;
        end else begin
            grant_id = REQ0;
        end
    end

    assign accept       = slot_ok & grant_valid;
    assign req0_ready   = slot_ok & req0_valid & (grant_id == REQ0);
    assign req1_ready   = slot_ok & req1_valid & (grant_id == REQ1);
    assign granted_data = (grant_id == REQ1) ? req1_data : req0_data;

    btr_calc u_calc (
        .din  (granted_data),
        .dout (rev_data)
    );

    // Slot FSM, owner/priority tracking and grant counters.
    // An acceptance reloads the slot even while the old result drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= EMPTY;
            owner_reg      <= REQ0;
            prio_reg       <= REQ0;
            result_reg     <= '0;
            grant_cnt0_reg <= 16'h0000;
            grant_cnt1_reg <= 16'h0000;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        state_reg <= HELD;
                    end
                end
                HELD: begin
                    if (drain && !accept) begin
                        state_reg <= EMPTY;
                    end
                end
                default: state_reg <= EMPTY;
            endcase

            if (accept) begin
                result_reg <= rev_data;
                owner_reg  <= grant_id;
                prio_reg   <= other_req(grant_id);
                if (grant_id == REQ0) begin
                    grant_cnt0_reg <= grant_cnt0_reg + 16'd1;
                end else begin
                    grant_cnt1_reg <= grant_cnt1_reg + 16'd1;
                end
            end
        end
    end

    // Response channels. Each channel is driven only when its requester owns
    // the held result. The data output is zero otherwise.
    assign resp0_valid = full & (owner_reg == REQ0);
    assign resp1_valid = full & (owner_reg == REQ1);
    assign resp0_data  = resp0_valid ? result_reg : '0;
    assign resp1_data  = resp1_valid ? result_reg : '0;
    assign grant_cnt0  = grant_cnt0_reg;
    assign grant_cnt1  = grant_cnt1_reg;

endmodule

// File: tb/tb_btr_arbiter.sv
// Bench for btr_arbiter: directed scenarios plus randomized traffic.
// The results are compared against a transaction-level reference model.
module tb_btr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [15:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready;
    logic        resp0_valid, resp1_valid;
    logic [15:0] resp0_data, resp1_data;
    logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic [15:0] grant_cnt0, grant_cnt1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit          m_full;
    int          m_owner;
    int          m_prio;
    logic [15:0] m_result;
    int          m_cnt [2];
    bit          m_acc0, m_acc1;

    btr_arbiter #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .resp0_valid (resp0_valid),
        .resp0_data  (resp0_data),
        .resp0_ready (resp0_ready),
        .resp1_valid (resp1_valid),
        .resp1_data  (resp1_data),
        .resp1_ready (resp1_ready),
        .grant_cnt0  (grant_cnt0),
        .grant_cnt1  (grant_cnt1)
    );

    always #5 clk = ~clk;

    // Bit reversal by shifting: the LSB goes out first and comes in at the bottom.
    function automatic logic [15:0] bitrev(input logic [15:0] x);
        logic [15:0] r = 16'h0000;
        logic [15:0] v = x;
        for (int i = 0; i < 16; i++) begin
            r = (r << 1) | (v & 16'h0001);
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int model_grant();
        if (req0_valid && req1_valid) return m_prio;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    function automatic bit model_slot_ok();
        bit owner_rdy = (m_owner == 0) ? resp0_ready : resp1_ready;
        return !m_full || owner_rdy;
    endfunction

    task automatic model_reset();
        m_full = 0; m_owner = 0; m_prio = 0; m_result = '0;
        m_cnt[0] = 0; m_cnt[1] = 0; m_acc0 = 0; m_acc1 = 0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compares every DUT output against the model at mid-cycle.
    task automatic check_all();
        int  g  = model_grant();
        bit  so = model_slot_ok();
        chk("req0_ready", {15'd0, req0_ready}, {15'd0, so && g == 0});
        chk("req1_ready", {15'd0, req1_ready}, {15'd0, so && g == 1});
        chk("resp0_valid", {15'd0, resp0_valid}, {15'd0, m_full && m_owner == 0});
        chk("resp1_valid", {15'd0, resp1_valid}, {15'd0, m_full && m_owner == 1});
        chk("resp0_data", resp0_data, (m_full && m_owner == 0) ? m_result : 16'h0000);
        chk("resp1_data", resp1_data, (m_full && m_owner == 1) ? m_result : 16'h0000);
        chk("grant_cnt0", grant_cnt0, m_cnt[0][15:0]);
        chk("grant_cnt1", grant_cnt1, m_cnt[1][15:0]);
    endtask

    // Applies one clock edge to the model, using the inputs present at that edge.
    task automatic model_edge();
        int g  = model_grant();
        bit so = model_slot_ok();
        bit dr = m_full && ((m_owner == 0) ? resp0_ready : resp1_ready);
        m_acc0 = so && g == 0;
        m_acc1 = so && g == 1;
        if (so && g >= 0) begin
            m_result = bitrev(g == 0 ? req0_data : req1_data);
            m_owner  = g;
            m_full   = 1;
            m_prio   = 1 - g;
            m_cnt[g] = (m_cnt[g] + 1) % 65536;
        end else if (dr) begin
            m_full = 0;
        end
    endtask

    // One cycle. Optionally checks the outputs, then advances to 1 time unit after the next rising edge.
    task automatic step(input bit do_check);
        #2;
        if (do_check) check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
        rst = 1;
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        model_reset();

        // Reset state
        #3;
        chk("rst_req0_ready", {15'd0, req0_ready}, 16'd0);
        chk("rst_req1_ready", {15'd0, req1_ready}, 16'd0);
        chk("rst_resp0_valid", {15'd0, resp0_valid}, 16'd0);
        chk("rst_resp1_valid", {15'd0, resp1_valid}, 16'd0);
        chk("rst_resp0_data", resp0_data, 16'h0000);
        chk("rst_cnt0", grant_cnt0, 16'h0000);
        do_reset();

        // Single requester
        req0_valid = 1; req0_data = 16'h1234; resp0_ready = 1;
        step(1);
        req0_valid = 0;
        #1;
        chk("single_resp0_valid", {15'd0, resp0_valid}, 16'd1);
        chk("single_resp0_data", resp0_data, 16'h2C48);
        chk("single_resp1_valid", {15'd0, resp1_valid}, 16'd0);
        chk("single_cnt0", grant_cnt0, 16'd1);
        step(1);

        // Contention fairness, starting from reset priority
        do_reset();
        req0_valid = 1; req0_data = 16'h0001;
        req1_valid = 1; req1_data = 16'h00FF;
        resp0_ready = 1; resp1_ready = 1;
        for (int k = 0; k < 6; k++) begin
            step(1);
            #1;
            chk("fair_resp0_valid", {15'd0, resp0_valid}, (k % 2 == 0) ? 16'd1 : 16'd0);
            chk("fair_resp1_valid", {15'd0, resp1_valid}, (k % 2 == 1) ? 16'd1 : 16'd0);
            chk("fair_data", resp0_data | resp1_data, (k % 2 == 0) ? 16'h8000 : 16'hFF00);
        end
        step(1);

        // Back-pressure
        do_reset();
        req0_valid = 1; req0_data = 16'hF00F; resp0_ready = 0; resp1_ready = 1;
        step(1);
        req0_valid = 0; req1_valid = 1; req1_data = 16'h0F0F;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_req0_ready", {15'd0, req0_ready}, 16'd0);
            chk("bp_req1_ready", {15'd0, req1_ready}, 16'd0);
            chk("bp_resp0_data", resp0_data, 16'hF00F);
            step(1);
        end
        resp0_ready = 1;
        #1;
        chk("bp_release_req1_ready", {15'd0, req1_ready}, 16'd1);
        step(1);
        req1_valid = 0;
        #1;
        chk("bp_resp1_valid", {15'd0, resp1_valid}, 16'd1);
        chk("bp_resp1_data", resp1_data, 16'hF0F0);
        chk("bp_resp0_valid", {15'd0, resp0_valid}, 16'd0);

        // Owner isolation: the result is held by req1, and only resp0 is ready
        resp0_ready = 1; resp1_ready = 0;
        req0_valid = 1; req0_data = 16'h5555;
        for (int k = 0; k < 3; k++) begin
            step(1);
            #1;
            chk("iso_resp1_valid", {15'd0, resp1_valid}, 16'd1);
            chk("iso_resp0_valid", {15'd0, resp0_valid}, 16'd0);
            chk("iso_req0_ready", {15'd0, req0_ready}, 16'd0);
        end

        // Asynchronous reset while HELD
        rst = 1;
        #1;
        model_reset();
        chk("arst_resp1_valid", {15'd0, resp1_valid}, 16'd0);
        chk("arst_resp0_valid", {15'd0, resp0_valid}, 16'd0);
        chk("arst_cnt0", grant_cnt0, 16'h0000);
        chk("arst_cnt1", grant_cnt1, 16'h0000);
        @(negedge clk);
        rst = 0;
        req0_valid = 0; req1_valid = 1; req1_data = 16'hABCD; resp1_ready = 1;
        #1;
        chk("arst_req1_ready", {15'd0, req1_ready}, 16'd1);
        chk("arst_req0_ready", {15'd0, req0_ready}, 16'd0);
        step(1);
        req1_valid = 0;
        #1;
        chk("arst_resp1_data", resp1_data, 16'hB3D5);
        step(1);

        // Randomized traffic under the hold-until-ready rule
        for (int c = 0; c < 400; c++) begin
            if (!req0_valid || m_acc0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_data  = 16'($urandom);
            end
            if (!req1_valid || m_acc1) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_data  = 16'($urandom);
            end
            resp0_ready = ($urandom_range(0, 3) != 0);
            resp1_ready = ($urandom_range(0, 3) != 0);
            m_acc0 = 0; m_acc1 = 0;
            step(1);
        end

        // Counter wrap
        do_reset();
        req0_valid = 1; req0_data = 16'h00F0; resp0_ready = 1;
        for (int k = 0; k < 65535; k++) step(0);
        #1;
        chk("wrap_cnt0_ffff", grant_cnt0, 16'hFFFF);
        step(1);
        #1;
        chk("wrap_cnt0_zero", grant_cnt0, 16'h0000);
        chk("wrap_resp0_data", resp0_data, 16'h0F00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
